// File: rtl/dual_issue_sched_if.sv
// Fetch/issue/occupancy bundle between the fetch stage, the dual-issue
// scheduler and the reservation stations.
interface dual_issue_sched_if #(
  parameter int DEPTH = 8,
  parameter int PCW   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           fetch_valid;
  logic [PCW-1:0] pc1_in;
  logic [PCW-1:0] pc2_in;
  logic [1:0]     rs_free;
  logic           flush;
  logic           stall;
  logic           issue0_valid;
  logic [PCW-1:0] issue0_pc;
  logic           issue1_valid;
  logic [PCW-1:0] issue1_pc;
  logic [CW-1:0]  count;

  modport master (
    output fetch_valid, pc1_in, pc2_in, rs_free, flush,
    input  stall, issue0_valid, issue0_pc, issue1_valid, issue1_pc, count
  );

  modport slave (
    input  fetch_valid, pc1_in, pc2_in, rs_free, flush,
    output stall, issue0_valid, issue0_pc, issue1_valid, issue1_pc, count
  );
endinterface

// File: rtl/dual_issue_sched.sv
// Dual-issue in-order scheduler: circular PC-pair queue between fetch and the
// reservation stations, issuing up to two entries per cycle, with flush handling.
module dual_issue_sched #(
  parameter int DEPTH     = 8,
  parameter int PCW       = 4,
  parameter int FLUSH_CYC = 1
) (
  input logic               clk,
  input logic               reset,
  dual_issue_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [FW-1:0]  r_fcnt;
  logic [FW-1:0]  w_fcnt_next;
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [PCW-1:0] r_mem [DEPTH];

  logic           w_stall;
  logic           w_push;
  logic [1:0]     w_n;
  logic [CW-1:0]  w_count_next;
  logic [AW-1:0]  w_head1;
  logic [AW-1:0]  w_tail1;

  // Issue width: rs_free saturated at 2, then clipped by the occupancy.
  function automatic logic [1:0] issue_width(input logic [1:0] rs, input logic [CW-1:0] cnt);
    logic [1:0] w_sat;
    w_sat = (rs == 2'd3) ? 2'd2 : rs;
    return (cnt < {{(CW-2){1'b0}}, w_sat}) ? cnt[1:0] : w_sat;
  endfunction

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);

  // Stall, push and issue decode; stall depends on registered state only.
  always_comb begin
    w_stall = (r_state == ST_FLUSH) || (r_count > CW'(DEPTH - 2));
    w_push  = bus.fetch_valid && !w_stall && !bus.flush;
    w_n     = 2'd0;
    if ((r_state == ST_RUN) && !bus.flush) begin
      w_n = issue_width(bus.rs_free, r_count);
    end else begin
      w_n = 2'd0;
    end
    w_count_next = r_count
                 + (w_push ? CW'(2) : CW'(0))
                 - {{(CW-2){1'b0}}, w_n};
  end

  // Next-state logic; a flush seen in FLUSH reloads the residency counter.
  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (bus.flush) begin
          w_state_next = ST_FLUSH;
          w_fcnt_next  = FW'(FLUSH_CYC - 1);
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.flush) begin
          w_fcnt_next = FW'(FLUSH_CYC - 1);
        end else if (r_fcnt == FW'(0)) begin
          w_state_next = ST_RUN;
        end else begin
          w_fcnt_next = r_fcnt - FW'(1);
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_fcnt_next  = FW'(0);
      end
    endcase
  end

  // State and flush counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= FW'(0);
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
    end
  end

  // Queue pointers and occupancy; a flush discards everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= AW'(0);
      r_tail  <= AW'(0);
      r_count <= CW'(0);
    end else if (bus.flush) begin
      r_head  <= AW'(0);
      r_tail  <= AW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(2);
      end
      r_head  <= r_head + AW'(w_n);
      r_count <= w_count_next;
    end
  end

  // Entry storage; written only on an accepted pair, never bypassed to issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {PCW{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_tail]  <= bus.pc1_in;
      r_mem[w_tail1] <= bus.pc2_in;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.issue0_valid = (w_n != 2'd0);
  assign bus.issue0_pc    = r_mem[r_head];
  assign bus.issue1_valid = (w_n == 2'd2);
  assign bus.issue1_pc    = r_mem[w_head1];
  assign bus.count        = r_count;
endmodule

// File: tb/tb_dual_issue_sched.sv
// Directed self-checking bench for dual_issue_sched with hand-computed expectations.
module tb_dual_issue_sched;
  localparam int DEPTH     = 8;
  localparam int PCW       = 4;
  localparam int FLUSH_CYC = 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dual_issue_sched_if #(.DEPTH(DEPTH), .PCW(PCW)) bus ();

  dual_issue_sched #(.DEPTH(DEPTH), .PCW(PCW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input int p1, input int p2, input int rs, input logic fl);
    bus.fetch_valid = fv;
    bus.pc1_in      = PCW'(p1);
    bus.pc2_in      = PCW'(p2);
    bus.rs_free     = 2'(rs);
    bus.flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string tag, input int v0, input int p0, input int v1, input int p1);
    check_val({tag, "_iv0"}, 32'(bus.issue0_valid), 32'(v0));
    if (v0 != 0) check_val({tag, "_pc0"}, 32'(bus.issue0_pc), 32'(p0));
    check_val({tag, "_iv1"}, 32'(bus.issue1_valid), 32'(v1));
    if (v1 != 0) check_val({tag, "_pc1"}, 32'(bus.issue1_pc), 32'(p1));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count", 32'(bus.count), 32'd0);
    check_val("rst_stall", 32'(bus.stall), 32'd0);
    chk_issue("rst", 0, 0, 0, 0);
    check_val("rst_pc0", 32'(bus.issue0_pc), 32'd0);
    check_val("rst_pc1", 32'(bus.issue1_pc), 32'd0);
    reset = 1'b0;

    // single pair, no bypass, then dual issue
    drive(1'b1, 0, 1, 0, 1'b0);
    #1;
    chk_issue("t1_empty", 0, 0, 0, 0);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    #1;
    check_val("t1_count2", 32'(bus.count), 32'd2);
    check_val("t1_stall", 32'(bus.stall), 32'd0);
    chk_issue("t1_rs0", 0, 0, 0, 0);
    drive(1'b0, 0, 0, 2, 1'b0);
    #1;
    chk_issue("t1_dual", 1, 0, 1, 1);
    tick();
    check_val("t1_count0", 32'(bus.count), 32'd0);

    // fill to stall
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2*k, 2*k+1, 0, 1'b0);
      #1;
      check_val("t2_stall_pre", 32'(bus.stall), 32'd0);
      tick();
      check_val("t2_count", 32'(bus.count), 32'(2*(k+1)));
    end
    check_val("t2_stall_full", 32'(bus.stall), 32'd1);
    drive(1'b1, 8, 9, 0, 1'b0);
    tick();
    check_val("t2_count_held", 32'(bus.count), 32'd8);
    check_val("t2_stall_held", 32'(bus.stall), 32'd1);

    // single issues, stall release, tail wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 0, 1, 1'b0);
      #1;
      chk_issue("t3_single", 1, i, 0, 0);
      tick();
      check_val("t3_count", 32'(bus.count), 32'(7 - i));
      check_val("t3_stall", 32'(bus.stall), (i == 0) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 8, 9, 0, 1'b0);
    tick();
    check_val("t3_wrap_count", 32'(bus.count), 32'd7);
    check_val("t3_wrap_stall", 32'(bus.stall), 32'd1);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 0, 0, 2, 1'b0);
      #1;
      chk_issue("t3_seq", 1, 3 + 2*j, 1, 4 + 2*j);
      tick();
      check_val("t3_seq_count", 32'(bus.count), 32'(5 - 2*j));
    end
    #1;
    chk_issue("t3_last", 1, 9, 0, 0);
    tick();
    check_val("t3_empty", 32'(bus.count), 32'd0);

    // simultaneous push and issue, rs_free=3 saturates to 2
    drive(1'b1, 10, 11, 0, 1'b0);
    tick();
    drive(1'b1, 12, 13, 0, 1'b0);
    tick();
    check_val("t4_count4", 32'(bus.count), 32'd4);
    drive(1'b1, 14, 15, 3, 1'b0);
    #1;
    chk_issue("t4_both", 1, 10, 1, 11);
    tick();
    check_val("t4_count_same", 32'(bus.count), 32'd4);
    drive(1'b0, 0, 0, 2, 1'b0);
    #1;
    chk_issue("t4_next", 1, 12, 1, 13);
    tick();
    chk_issue("t4_pushed", 1, 14, 1, 15);
    tick();
    check_val("t4_empty", 32'(bus.count), 32'd0);

    // flush mid-stream with nonzero head
    drive(1'b1, 1, 2, 0, 1'b0);
    tick();
    drive(1'b1, 3, 4, 0, 1'b0);
    tick();
    drive(1'b1, 5, 6, 0, 1'b0);
    tick();
    drive(1'b1, 7, 8, 2, 1'b0);
    #1;
    chk_issue("t5_pre", 1, 1, 1, 2);
    tick();
    check_val("t5_count6", 32'(bus.count), 32'd6);
    drive(1'b1, 7, 0, 2, 1'b1);
    #1;
    chk_issue("t5_flush_cyc", 0, 0, 0, 0);
    tick();
    drive(1'b1, 11, 13, 2, 1'b0);
    #1;
    check_val("t5_count0", 32'(bus.count), 32'd0);
    check_val("t5_stall_hi", 32'(bus.stall), 32'd1);
    chk_issue("t5_in_flush", 0, 0, 0, 0);
    tick();
    check_val("t5_stall_lo", 32'(bus.stall), 32'd0);
    check_val("t5_no_push", 32'(bus.count), 32'd0);
    drive(1'b1, 11, 13, 0, 1'b0);
    tick();
    check_val("t5_pushed", 32'(bus.count), 32'd2);
    drive(1'b0, 0, 0, 2, 1'b0);
    #1;
    chk_issue("t5_head0", 1, 11, 1, 13);
    tick();

    // asynchronous reset between edges
    drive(1'b1, 9, 10, 0, 1'b0);
    tick();
    drive(1'b1, 11, 12, 0, 1'b0);
    tick();
    drive(1'b1, 13, 14, 0, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1, 1'b0);
    #1;
    chk_issue("t6_pre", 1, 9, 0, 0);
    tick();
    check_val("t6_count5", 32'(bus.count), 32'd5);
    drive(1'b0, 0, 0, 2, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_val("t6_async_count", 32'(bus.count), 32'd0);
    check_val("t6_async_stall", 32'(bus.stall), 32'd0);
    chk_issue("t6_async", 0, 0, 0, 0);
    check_val("t6_async_pc0", 32'(bus.issue0_pc), 32'd0);
    reset = 1'b0;
    drive(1'b1, 5, 7, 0, 1'b0);
    tick();
    check_val("t6_resume_count", 32'(bus.count), 32'd2);
    drive(1'b0, 0, 0, 2, 1'b0);
    #1;
    chk_issue("t6_resume", 1, 5, 1, 7);
    tick();
    check_val("t6_final", 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
